// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller.
package uart_frame_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_frame_rx.sv
// Assembles UART bytes MSB-first into a command word and drops stale partial
// frames after an inter-byte timeout.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned CMD_BYTES = 3,
    parameter int unsigned TIMEOUT   = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_rdy,
    input  logic [BYTE_W-1:0]           rx_data,
    output logic                        clr_rx_rdy,
    output logic [CMD_BYTES*BYTE_W-1:0] cmd,
    output logic                        cmd_rdy,
    input  logic                        clr_cmd_rdy,
    output logic                        frm_err
);

    localparam int unsigned CNT_W = $clog2(CMD_BYTES);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned CMD_W = CMD_BYTES * BYTE_W;
    localparam int unsigned SHF_W = (CMD_BYTES - 1) * BYTE_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMD_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic [CNT_W-1:0] r_rx_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [SHF_W-1:0] r_cmd_shift;
    logic [CMD_W-1:0] r_cmd;
    logic             r_cmd_rdy;
    logic             r_clr_rx_rdy;
    logic             r_frm_err;

    logic             w_accept;
    logic             w_first;
    logic             w_last;
    logic             w_timeout;
    logic [CMD_W-1:0] w_word;

    // rx_rdy is still high while our acknowledge pulse is out; masking with it
    // keeps the same byte from being taken twice.
    assign w_accept  = rx_rdy & ~r_clr_rx_rdy;
    assign w_first   = w_accept & (r_rx_cnt == '0);
    assign w_last    = w_accept & (r_rx_cnt == CNT_LAST);
    assign w_timeout = ~w_accept & (r_rx_cnt != '0) & (r_tmo_cnt == TMO_ONE);
    assign w_word    = {r_cmd_shift, rx_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_cnt     <= '0;
            r_tmo_cnt    <= '0;
            r_cmd_shift  <= '0;
            r_cmd        <= '0;
            r_cmd_rdy    <= 1'b0;
            r_clr_rx_rdy <= 1'b0;
            r_frm_err    <= 1'b0;
        end else begin
            r_clr_rx_rdy <= w_accept;
            r_frm_err    <= w_timeout;

            if (w_accept) begin
                r_cmd_shift <= w_word[SHF_W-1:0];
                r_tmo_cnt   <= TMO_LOAD;
                r_rx_cnt    <= w_last ? '0 : r_rx_cnt + 1'b1;
            end else if (w_timeout) begin
                r_rx_cnt  <= '0;
                r_tmo_cnt <= '0;
            end else if (r_rx_cnt != '0) begin
                r_tmo_cnt <= r_tmo_cnt - 1'b1;
            end

            if (w_last) begin
                r_cmd <= w_word;
            end

            // A newly completed frame beats an acknowledge in the same cycle;
            // the first byte of a new frame retires an unacknowledged one.
            if (w_last) begin
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy || w_first) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign clr_rx_rdy = r_clr_rx_rdy;
    assign cmd        = r_cmd;
    assign cmd_rdy    = r_cmd_rdy;
    assign frm_err    = r_frm_err;

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame-level sequencer for the byte UART: command assembly on RX and
// MSB-first response serialization on TX.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int unsigned CMD_BYTES = 3,
    parameter int unsigned RSP_BYTES = 2,
    parameter int unsigned TIMEOUT   = 50000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_rdy,
    input  logic [BYTE_W-1:0]           rx_data,
    output logic                        clr_rx_rdy,
    input  logic                        tx_done,
    output logic                        trmt,
    output logic [BYTE_W-1:0]           tx_data,
    output logic [CMD_BYTES*BYTE_W-1:0] cmd,
    output logic                        cmd_rdy,
    input  logic                        clr_cmd_rdy,
    output logic                        frm_err,
    input  logic                        send_rsp,
    input  logic [RSP_BYTES*BYTE_W-1:0] rsp_data,
    output logic                        rsp_busy,
    output logic                        rsp_done,
    output logic [1:0]                  dbg_tx_state
);

    localparam int unsigned RSP_W = RSP_BYTES * BYTE_W;
    localparam int unsigned TXC_W = $clog2(RSP_BYTES + 1);
    localparam logic [TXC_W-1:0] TXC_LAST = TXC_W'(RSP_BYTES - 1);

    uart_frame_rx #(
        .CMD_BYTES (CMD_BYTES),
        .TIMEOUT   (TIMEOUT)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .frm_err     (frm_err)
    );

    tx_state_t        r_tx_state;
    tx_state_t        w_tx_next;
    logic [RSP_W-1:0] r_tx_shift;
    logic [TXC_W-1:0] r_tx_cnt;
    logic             r_rsp_busy;
    logic             r_rsp_done;
    logic             r_wait_first;

    logic             w_trmt;
    logic             w_load;
    logic             w_advance;
    logic             w_finish;

    always_comb begin
        w_tx_next = r_tx_state;
        w_trmt    = 1'b0;
        w_load    = 1'b0;
        w_advance = 1'b0;
        w_finish  = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (send_rsp) begin
                    w_load    = 1'b1;
                    w_tx_next = TX_SEND;
                end
            end
            TX_SEND: begin
                w_trmt    = 1'b1;
                w_tx_next = TX_WAIT;
            end
            TX_WAIT: begin
                // tx_done may still be high from the previous byte right after trmt
                if (!r_wait_first && tx_done) begin
                    if (r_tx_cnt == TXC_LAST) begin
                        w_finish  = 1'b1;
                        w_tx_next = TX_IDLE;
                    end else begin
                        w_advance = 1'b1;
                        w_tx_next = TX_SEND;
                    end
                end
            end
            default: begin
                w_tx_next = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state   <= TX_IDLE;
            r_tx_shift   <= '0;
            r_tx_cnt     <= '0;
            r_rsp_busy   <= 1'b0;
            r_rsp_done   <= 1'b0;
            r_wait_first <= 1'b0;
        end else begin
            r_tx_state   <= w_tx_next;
            r_wait_first <= w_trmt;
            r_rsp_done   <= w_finish;
            if (w_load) begin
                r_tx_shift <= rsp_data;
                r_tx_cnt   <= '0;
                r_rsp_busy <= 1'b1;
            end else if (w_advance) begin
                r_tx_shift <= r_tx_shift << BYTE_W;
                r_tx_cnt   <= r_tx_cnt + 1'b1;
            end else if (w_finish) begin
                r_rsp_busy <= 1'b0;
            end
        end
    end

    assign trmt         = w_trmt;
    assign tx_data      = r_tx_shift[RSP_W-1 -: BYTE_W];
    assign rsp_busy     = r_rsp_busy;
    assign rsp_done     = r_rsp_done;
    assign dbg_tx_state = r_tx_state;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl with behavioural UART RX/TX models
// and queue-based scoreboards for command words and transmitted bytes.
module tb_uart_frame_ctrl;

    localparam int CMD_BYTES = 3;
    localparam int RSP_BYTES = 2;
    localparam int TIMEOUT   = 40;
    localparam int TX_LAT    = 4;
    localparam int CW        = CMD_BYTES * 8;
    localparam int RW        = RSP_BYTES * 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          clr_rx_rdy;
    logic          tx_done;
    logic          trmt;
    logic [7:0]    tx_data;
    logic [CW-1:0] cmd;
    logic          cmd_rdy;
    logic          clr_cmd_rdy;
    logic          frm_err;
    logic          send_rsp;
    logic [RW-1:0] rsp_data;
    logic          rsp_busy;
    logic          rsp_done;
    logic [1:0]    dbg_tx_state;

    uart_frame_ctrl #(
        .CMD_BYTES (CMD_BYTES),
        .RSP_BYTES (RSP_BYTES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_rdy       (rx_rdy),
        .rx_data      (rx_data),
        .clr_rx_rdy   (clr_rx_rdy),
        .tx_done      (tx_done),
        .trmt         (trmt),
        .tx_data      (tx_data),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .frm_err      (frm_err),
        .send_rsp     (send_rsp),
        .rsp_data     (rsp_data),
        .rsp_busy     (rsp_busy),
        .rsp_done     (rsp_done),
        .dbg_tx_state (dbg_tx_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [CW-1:0] cmd_exp_q[$];
    logic [7:0]    tx_exp_q[$];

    int   n_clr = 0;
    int   n_frm = 0;
    int   n_trmt = 0;
    int   n_rsp_done = 0;
    int   tx_idx = 0;
    int   done_cyc = 0;
    logic prev_cmd_rdy = 1'b0;
    logic prev_tx_done = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_cmd_rdy = 1'b0;
            prev_tx_done = tx_done;
            tx_idx       = 0;
        end else begin
            if (clr_rx_rdy) n_clr++;
            if (frm_err) n_frm++;
            if (cmd_rdy && !prev_cmd_rdy) begin
                check("cmd_q_occupancy", cmd_exp_q.size() != 0, 1);
                if (cmd_exp_q.size() != 0) check("cmd_word", cmd, cmd_exp_q.pop_front());
            end
            prev_cmd_rdy = cmd_rdy;
            if (tx_done && !prev_tx_done) done_cyc = cyc;
            prev_tx_done = tx_done;
            if (trmt) begin
                n_trmt++;
                check("rsp_busy_at_trmt", rsp_busy, 1);
                if (tx_idx != 0) check("trmt_after_tx_done", cyc - done_cyc, 1);
                check("tx_q_occupancy", tx_exp_q.size() != 0, 1);
                if (tx_exp_q.size() != 0) check("tx_byte", tx_data, tx_exp_q.pop_front());
                tx_idx++;
            end
            if (rsp_done) begin
                n_rsp_done++;
                check("rsp_done_after_tx_done", cyc - done_cyc, 1);
                check("rsp_done_byte_count", tx_idx, RSP_BYTES);
                tx_idx = 0;
            end
        end
    end

    // ---------------- behavioural UART transmitter ----------------
    bit stale_hold = 1'b0;

    initial begin
        tx_done = 1'b1;
        forever begin
            @(negedge clk);
            if (trmt && !rst) begin
                // stale_hold keeps the old tx_done high through the first wait cycle
                if (stale_hold) @(posedge clk);
                @(posedge clk);
                #1 tx_done = 1'b0;
                repeat (TX_LAT) @(posedge clk);
                #1 tx_done = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic rx_byte(input logic [7:0] b, input bit ack_same);
        int n;
        @(posedge clk);
        #1 rx_data = b;
        rx_rdy      = 1'b1;
        clr_cmd_rdy = ack_same;
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b0;
        n = 0;
        @(negedge clk);
        while (!clr_rx_rdy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("clr_rx_rdy_seen", clr_rx_rdy, 1);
        @(posedge clk);
        #1 rx_rdy = 1'b0;
    endtask

    task automatic rx_frame(input logic [CW-1:0] w, input int gap);
        for (int i = CMD_BYTES - 1; i >= 0; i--) begin
            rx_byte(w[i*8 +: 8], 1'b0);
            repeat (gap) @(posedge clk);
        end
    endtask

    task automatic send(input logic [RW-1:0] w, input bit expect_taken);
        @(posedge clk);
        #1 send_rsp = 1'b1;
        rsp_data = w;
        if (expect_taken)
            for (int i = RSP_BYTES - 1; i >= 0; i--) tx_exp_q.push_back(w[i*8 +: 8]);
        @(posedge clk);
        #1 send_rsp = 1'b0;
        rsp_data = '0;
    endtask

    task automatic wait_rsp_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (rsp_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rsp_idle_in_time", rsp_busy, 0);
        repeat (8) @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_trmt", trmt, 0);
        check("rst_rsp_busy", rsp_busy, 0);
        check("rst_cmd_rdy", cmd_rdy, 0);
        tx_exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int base_clr;
    int base_frm;
    int base_done;
    int base_trmt;
    int n_wait;

    initial begin
        rst = 1'b1;
        rx_rdy = 1'b0;
        rx_data = '0;
        clr_cmd_rdy = 1'b0;
        send_rsp = 1'b0;
        rsp_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_flags", {clr_rx_rdy, trmt, cmd_rdy, frm_err, rsp_busy, rsp_done}, 0);
        check("reset_cmd", cmd, 0);
        check("reset_tx_data", tx_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // frame assembly, bytes 10 clocks apart
        base_clr = n_clr;
        base_frm = n_frm;
        cmd_exp_q.push_back(24'hA5123C);
        rx_frame(24'hA5123C, 10);
        @(negedge clk);
        check("f1_cmd_rdy", cmd_rdy, 1);
        check("f1_clr_pulses", n_clr - base_clr, 3);
        check("f1_no_frm_err", n_frm - base_frm, 0);
        check("f1_cmd_drained", cmd_exp_q.size(), 0);

        // acknowledge
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b0;
        @(negedge clk);
        check("ack_clears_cmd_rdy", cmd_rdy, 0);

        // timeout of a partial frame
        base_frm = n_frm;
        rx_byte(8'h11, 1'b0);
        rx_byte(8'h22, 1'b0);
        repeat (TIMEOUT - 5) @(posedge clk);
        @(negedge clk);
        check("no_early_timeout", n_frm - base_frm, 0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("timeout_frm_err_once", n_frm - base_frm, 1);
        check("timeout_cmd_kept", cmd, 24'hA5123C);
        check("timeout_cmd_rdy_kept", cmd_rdy, 0);
        cmd_exp_q.push_back(24'h010203);
        rx_frame(24'h010203, 2);
        @(negedge clk);
        check("post_timeout_cmd_rdy", cmd_rdy, 1);
        check("post_timeout_drained", cmd_exp_q.size(), 0);

        // overrun: new frame without acknowledge
        cmd_exp_q.push_back(24'h0A0B0C);
        rx_byte(8'h0A, 1'b0);
        @(negedge clk);
        check("overrun_cmd_rdy_drop", cmd_rdy, 0);
        check("overrun_cmd_hold", cmd, 24'h010203);
        rx_byte(8'h0B, 1'b0);
        rx_byte(8'h0C, 1'b0);
        @(negedge clk);
        check("overrun_cmd_rdy_rise", cmd_rdy, 1);

        // acknowledge in the same cycle the frame completes
        cmd_exp_q.push_back(24'h445566);
        rx_byte(8'h44, 1'b0);
        rx_byte(8'h55, 1'b0);
        rx_byte(8'h66, 1'b1);
        @(negedge clk);
        check("set_beats_clear", cmd_rdy, 1);
        check("cmd_q_drained", cmd_exp_q.size(), 0);

        // response transmission
        base_done = n_rsp_done;
        send(16'hBEEF, 1'b1);
        @(negedge clk);
        check("first_trmt_latency", trmt, 1);
        check("rsp_busy_after_send", rsp_busy, 1);
        wait_rsp_idle();
        check("beef_rsp_done_once", n_rsp_done - base_done, 1);
        check("beef_tx_drained", tx_exp_q.size(), 0);

        // send_rsp while busy is ignored
        base_done = n_rsp_done;
        send(16'h5678, 1'b1);
        repeat (3) @(posedge clk);
        send(16'h1234, 1'b0);
        wait_rsp_idle();
        check("busy_rsp_done_once", n_rsp_done - base_done, 1);
        check("busy_tx_drained", tx_exp_q.size(), 0);

        // stale tx_done held over the first wait cycle
        stale_hold = 1'b1;
        base_done = n_rsp_done;
        send(16'h9ABC, 1'b1);
        wait_rsp_idle();
        stale_hold = 1'b0;
        check("stale_rsp_done_once", n_rsp_done - base_done, 1);
        check("stale_tx_drained", tx_exp_q.size(), 0);

        // reset during the second TX byte while a command is pending
        send(16'hCAFE, 1'b1);
        n_wait = 0;
        while (tx_idx < 2 && n_wait < 100) begin
            @(negedge clk);
            n_wait++;
        end
        check("second_byte_reached", tx_idx >= 2, 1);
        check("pre_reset_cmd_rdy", cmd_rdy, 1);
        pulse_reset();
        check("post_reset_cmd", cmd, 0);
        base_trmt = n_trmt;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("no_trmt_after_reset", n_trmt - base_trmt, 0);
        check("no_busy_after_reset", rsp_busy, 0);

        // reset mid RX frame, then a clean frame
        rx_byte(8'h55, 1'b0);
        rx_byte(8'h66, 1'b0);
        pulse_reset();
        base_clr = n_clr;
        base_frm = n_frm;
        cmd_exp_q.push_back(24'hA5123C);
        rx_frame(24'hA5123C, 10);
        @(negedge clk);
        check("rst_f_cmd_rdy", cmd_rdy, 1);
        check("rst_f_cmd", cmd, 24'hA5123C);
        check("rst_f_clr_pulses", n_clr - base_clr, 3);
        check("rst_f_no_frm_err", n_frm - base_frm, 0);

        check("final_cmd_q_empty", cmd_exp_q.size(), 0);
        check("final_tx_q_empty", tx_exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
